fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of control_unit.
- Holds the program counter and runs a req/ack transaction against instruction memory.
- Latches the returned 24-bit word into an instruction register whose output drives control_unit's code input.
- Supports a consumer stall and a branch/jump redirect from the execute stage, and discards stale in-flight fetches.

Parameters:
- ADDR_W, 8, PC and instruction-memory address width in words.
- INSTR_W, 24, instruction width; must equal control_unit code width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- imem_req  output  1  fetch request, held until imem_ack.
- imem_addr  output  ADDR_W  fetch address; stable while imem_req=1.
- imem_ack  input  1  one-cycle pulse; imem_rdata valid in the same cycle.
- imem_rdata  input  INSTR_W  fetched instruction word.
- code  output  INSTR_W  instruction register; feeds control_unit.
- code_valid  output  1  code holds a live instruction.
- pc  output  ADDR_W  address of the instruction in code.
- stall  input  1  consumer not accepting this cycle.
- branch_taken  input  1  one-cycle redirect pulse.
- branch_target  input  ADDR_W  redirect address, sampled when branch_taken=1.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - Outputs: pc_next=RESET_PC, pc=RESET_PC, code=0, code_valid=0, imem_req=0, kill=0.
  - State goes to FETCH.
  - Reset overrides every other input, including mid-transaction; an ack arriving during reset is ignored.
- States: FETCH, ISSUE, DRAIN.
- FETCH:
  - imem_req=1 and imem_addr=pc_next, both combinational from state.
  - On imem_ack with no branch: code<=imem_rdata, pc<=pc_next, pc_next<=pc_next+1 (mod 2^ADDR_W), code_valid<=1, go to ISSUE.
  - Minimum latency: ack in the first FETCH cycle gives code_valid high the next cycle.
- ISSUE:
  - imem_req=0; code and pc held.
  - Instruction is consumed when code_valid=1 and stall=0. On that edge: code_valid<=0, go to FETCH.
  - stall=1: hold everything indefinitely.
- DRAIN:
  - Entered when a branch hits an outstanding request.
  - imem_req=1 with the old address held.
  - On imem_ack: discard imem_rdata, go to FETCH with pc_next unchanged (already the branch target).
- Branch handling: branch_taken has priority over stall and ack.
  - ISSUE: code_valid<=0, pc_next<=branch_target, go to FETCH. The held instruction is squashed, even if stall=1.
  - FETCH, no ack in the same cycle: pc_next<=branch_target, go to DRAIN.
  - FETCH, ack in the same cycle: discard the data, pc_next<=branch_target, stay in FETCH. The new request issues with the target address next cycle.
  - DRAIN: pc_next<=branch_target, stay in DRAIN. The last target wins.
- Protocol and arithmetic rules:
  - imem_ack while imem_req=0 is ignored. A verification assertion flags it.
  - PC wrap: 2^ADDR_W-1 increments to 0 with no flag.
  - code is never modified while code_valid=1, except on reset or a branch squash. A squash clears code_valid only; code keeps its old value.
  - Invariant: code_valid=1 only in ISSUE.

Decomposition:
- Shared package cpu_pkg, holding:
  - INSTR_W=24
  - fetch state encoding: FETCH=2'd0, ISSUE=2'd1, DRAIN=2'd2
  - NOP_CODE=24'h000000
  - instruction-class field position [23:22], shared with control_unit
- One sub-module, pc_counter, containing:
  - pc_next register with synchronous active-low reset to RESET_PC
  - load (branch_target) and increment enables
  - load has priority over increment

Test Plan:
- Reset then ack on the 3rd FETCH cycle with rdata=24'h400000 → imem_addr=0 throughout, code=24'h400000, pc=0, code_valid=1 next cycle; next request addr=1.
- Back-to-back fetches, zero-wait ack, stall=0 → new instruction every 2 cycles; addresses 0,1,2,3; pc tracks them.
- stall=1 for 5 cycles in ISSUE with code=24'hC01000 → code and code_valid unchanged, imem_req=0; release → FETCH addr=pc+1.
- branch_taken in FETCH (target=8'h20) with ack 2 cycles later carrying 24'h800001 → data discarded, code_valid stays 0, imem_addr held until ack, then next request at 8'h20.
- branch_taken coincident with ack, and branch_taken with stall=1 in ISSUE (target=8'h10) → no instruction issued, code_valid=0, next request at 8'h10.
- RESET_PC=8'hFF: fetch → pc=FF, next addr=00. reset_n=0 asserted mid-DRAIN → all outputs return to reset values next cycle, restart at FF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, fetch FSM
// encoding and instruction-class field position.
package cpu_pkg;

    localparam int INSTR_W = 24;

    localparam logic [INSTR_W-1:0] NOP_CODE = 24'h000000;

    // Instruction-class field, decoded by control_unit.
    localparam int CLASS_HI = 23;
    localparam int CLASS_LO = 22;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic [1:0] instr_class(
        input logic [INSTR_W-1:0] word
    );
        return word[CLASS_HI:CLASS_LO];
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Next-fetch address register: a branch load wins
// over the sequential increment.
module pc_counter #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              incr,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] value
);

    // Load, increment (wrapping) or hold the address.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value <= RESET_PC;
        end else if (load) begin
            value <= target;
        end else if (incr) begin
            value <= value + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: req/ack fetch into the
// instruction register, with stall, redirect and drain.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] code,
    output logic               code_valid,
    output logic [ADDR_W-1:0]  pc,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target
);

    fetch_state_e state_q;
    fetch_state_e state_d;

    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] addr_q;
    logic              pc_load;
    logic              pc_incr;
    logic              take;
    logic              squash;
    logic              req_raw;

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (pc_load),
        .incr    (pc_incr),
        .target  (branch_target),
        .value   (pc_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control strobes; branch beats stall and ack.
    always_comb begin
        state_d = state_q;
        req_raw = 1'b0;
        pc_load = 1'b0;
        pc_incr = 1'b0;
        take    = 1'b0;
        squash  = 1'b0;
        unique case (state_q)
            FETCH: begin
                req_raw = 1'b1;
                if (branch_taken) begin
                    pc_load = 1'b1;
                    state_d = imem_ack ? FETCH : DRAIN;
                end else if (imem_ack) begin
                    take    = 1'b1;
                    pc_incr = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (branch_taken) begin
                    pc_load = 1'b1;
                    squash  = 1'b1;
                    state_d = FETCH;
                end else if (code_valid && !stall) begin
                    squash  = 1'b1;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                req_raw = 1'b1;
                if (branch_taken) begin
                    pc_load = 1'b1;
                end else if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign imem_req  = req_raw && reset_n;
    assign imem_addr = (state_q == DRAIN) ? addr_q : pc_next;

    // Remember the outstanding address so a drain can hold it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q <= RESET_PC;
        end else if (state_q == FETCH) begin
            addr_q <= pc_next;
        end
    end

    // Instruction register; a squash drops valid but keeps code.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            code       <= NOP_CODE;
            code_valid <= 1'b0;
            pc         <= RESET_PC;
        end else if (take) begin
            code       <= imem_rdata;
            code_valid <= 1'b1;
            pc         <= pc_next;
        end else if (squash) begin
            code_valid <= 1'b0;
        end
    end

    a_ack_needs_req: assert property (
        @(posedge clk) disable iff (!reset_n)
        imem_ack |-> imem_req
    );

    a_valid_in_issue: assert property (
        @(posedge clk) disable iff (!reset_n)
        code_valid |-> (state_q == ISSUE)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table,
// scoreboard of issued instructions, corner sequences.
module tb_fetch_unit;

    typedef struct {
        logic [23:0] rdata;
        int          wait_c;
        int          stall_c;
        logic [7:0]  addr;
    } vec_t;

    typedef struct {
        logic [23:0] code;
        logic [7:0]  pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [23:0] imem_rdata = '0;
    logic [23:0] code;
    logic        code_valid;
    logic [7:0]  pc;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = '0;

    logic        rst2_n = 1'b0;
    logic        req2;
    logic [7:0]  addr2;
    logic        ack2 = 1'b0;
    logic [23:0] rdata2 = '0;
    logic [23:0] code2;
    logic        valid2;
    logic [7:0]  pc2;
    logic        stall2 = 1'b0;
    logic        br2 = 1'b0;
    logic [7:0]  tgt2 = '0;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t e;
    logic prev_v = 1'b0;
    vec_t tbl[4];

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (8),
        .INSTR_W  (24),
        .RESET_PC (8'h00)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .code          (code),
        .code_valid    (code_valid),
        .pc            (pc),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target)
    );

    fetch_unit #(
        .ADDR_W   (8),
        .INSTR_W  (24),
        .RESET_PC (8'hFF)
    ) dut_ff (
        .clk           (clk),
        .reset_n       (rst2_n),
        .imem_req      (req2),
        .imem_addr     (addr2),
        .imem_ack      (ack2),
        .imem_rdata    (rdata2),
        .code          (code2),
        .code_valid    (valid2),
        .pc            (pc2),
        .stall         (stall2),
        .branch_taken  (br2),
        .branch_target (tgt2)
    );

    task automatic chk(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every new instruction must match a fetch.
    always @(negedge clk) begin
        if (reset_n && code_valid && !prev_v) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: code %h pc %h",
                         code, pc);
            end else begin
                e = sb.pop_front();
                chk("sb_code", 32'(code), 32'(e.code));
                chk("sb_pc", 32'(pc), 32'(e.pc));
            end
        end
        prev_v = code_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t limit 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{24'h100001, 0, 0, 8'h00};
        tbl[1] = '{24'h200002, 0, 0, 8'h01};
        tbl[2] = '{24'hC01000, 0, 5, 8'h02};
        tbl[3] = '{24'h000003, 1, 0, 8'h03};

        // Reset state
        tick();
        tick();
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_valid", 32'(code_valid), 0);
        chk("rst_code", 32'(code), 0);
        chk("rst_pc", 32'(pc), 0);

        // Ack on the third FETCH cycle
        reset_n = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("t1_req", 32'(imem_req), 1);
            chk("t1_addr", 32'(imem_addr), 0);
            tick();
        end
        chk("t1_addr3", 32'(imem_addr), 0);
        imem_ack   = 1'b1;
        imem_rdata = 24'h400000;
        sb.push_back('{24'h400000, 8'h00});
        tick();
        imem_ack = 1'b0;
        chk("t1_code", 32'(code), 32'h400000);
        chk("t1_pc", 32'(pc), 0);
        chk("t1_valid", 32'(code_valid), 1);
        chk("t1_req_issue", 32'(imem_req), 0);
        tick();
        chk("t1_next_req", 32'(imem_req), 1);
        chk("t1_next_addr", 32'(imem_addr), 1);

        // Table: back-to-back fetches, waits and stalls
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        foreach (tbl[k]) begin
            for (int w = 0; w < tbl[k].wait_c; w++) begin
                chk("v_wait_req", 32'(imem_req), 1);
                chk("v_wait_addr", 32'(imem_addr),
                    32'(tbl[k].addr));
                tick();
            end
            chk("v_req", 32'(imem_req), 1);
            chk("v_addr", 32'(imem_addr), 32'(tbl[k].addr));
            imem_ack   = 1'b1;
            imem_rdata = tbl[k].rdata;
            sb.push_back('{tbl[k].rdata, tbl[k].addr});
            tick();
            imem_ack = 1'b0;
            chk("v_valid", 32'(code_valid), 1);
            chk("v_pc", 32'(pc), 32'(tbl[k].addr));
            stall = 1'b1;
            for (int s = 0; s < tbl[k].stall_c; s++) begin
                tick();
                chk("v_stall_code", 32'(code),
                    32'(tbl[k].rdata));
                chk("v_stall_valid", 32'(code_valid), 1);
                chk("v_stall_req", 32'(imem_req), 0);
            end
            stall = 1'b0;
            tick();
        end
        chk("v_after_addr", 32'(imem_addr), 4);

        // Branch in FETCH, ack two cycles later
        branch_taken  = 1'b1;
        branch_target = 8'h20;
        tick();
        branch_taken = 1'b0;
        chk("dr_req", 32'(imem_req), 1);
        chk("dr_addr", 32'(imem_addr), 4);
        tick();
        chk("dr_addr2", 32'(imem_addr), 4);
        imem_ack   = 1'b1;
        imem_rdata = 24'h800001;
        tick();
        imem_ack = 1'b0;
        chk("dr_valid", 32'(code_valid), 0);
        chk("dr_new_req", 32'(imem_req), 1);
        chk("dr_new_addr", 32'(imem_addr), 32'h20);

        // Branch coincident with ack
        imem_ack      = 1'b1;
        imem_rdata    = 24'h123456;
        branch_taken  = 1'b1;
        branch_target = 8'h30;
        tick();
        imem_ack     = 1'b0;
        branch_taken = 1'b0;
        chk("co_valid", 32'(code_valid), 0);
        chk("co_req", 32'(imem_req), 1);
        chk("co_addr", 32'(imem_addr), 32'h30);

        // Branch squashes a stalled instruction
        imem_ack   = 1'b1;
        imem_rdata = 24'hABCDEF;
        sb.push_back('{24'hABCDEF, 8'h30});
        tick();
        imem_ack = 1'b0;
        chk("sq_valid_pre", 32'(code_valid), 1);
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 8'h10;
        tick();
        stall        = 1'b0;
        branch_taken = 1'b0;
        chk("sq_valid", 32'(code_valid), 0);
        chk("sq_code_kept", 32'(code), 32'hABCDEF);
        chk("sq_req", 32'(imem_req), 1);
        chk("sq_addr", 32'(imem_addr), 32'h10);

        // RESET_PC = FF: wrap, then reset during DRAIN
        rst2_n = 1'b1;
        #1;
        chk("ff_req", 32'(req2), 1);
        chk("ff_addr", 32'(addr2), 32'hFF);
        ack2   = 1'b1;
        rdata2 = 24'h111111;
        tick();
        ack2 = 1'b0;
        chk("ff_pc", 32'(pc2), 32'hFF);
        chk("ff_code", 32'(code2), 32'h111111);
        tick();
        chk("ff_wrap_addr", 32'(addr2), 0);
        br2  = 1'b1;
        tgt2 = 8'h55;
        tick();
        br2 = 1'b0;
        chk("ff_drain_addr", 32'(addr2), 0);
        chk("ff_drain_req", 32'(req2), 1);
        rst2_n = 1'b0;
        ack2   = 1'b1;
        rdata2 = 24'h777777;
        tick();
        ack2 = 1'b0;
        chk("ffr_req", 32'(req2), 0);
        chk("ffr_valid", 32'(valid2), 0);
        chk("ffr_code", 32'(code2), 0);
        chk("ffr_pc", 32'(pc2), 32'hFF);
        rst2_n = 1'b1;
        #1;
        chk("ffr_restart_req", 32'(req2), 1);
        chk("ffr_restart_addr", 32'(addr2), 32'hFF);

        tick();
        chk("sb_empty", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
